// File: rtl/jacobian_to_affine.sv
// rtl/jacobian_to_affine.sv - secp256k1 Jacobian-to-affine conversion via Fermat inversion on one shared modular multiplier

// Modular multiplier for primes of the form 2^256 - C with C < 2^64.
// Result is registered one cycle after start; done is a one-cycle pulse.
module jacobian_to_affine_mod_mul #(
  parameter logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic [255:0] result,
  output logic         done
);
  // 2^256 mod P; the folds below rely on this being small
  localparam logic [256:0] C_FULL = {1'b1, 256'd0} - {1'b0, P};
  localparam logic [63:0]  C      = C_FULL[63:0];

  logic [511:0] prod;
  logic [320:0] t1;
  logic [256:0] t2;
  logic [255:0] red;

  // Full product, two folds of the high half by C, then one conditional subtract
  always_comb begin
    prod = {256'd0, a} * {256'd0, b};
    t1   = {65'd0, prod[255:0]} + ({65'd0, prod[511:256]} * {257'd0, C});
    t2   = {1'b0, t1[255:0]} + ({192'd0, t1[320:256]} * {193'd0, C});
    red  = (t2 >= {1'b0, P}) ? (t2[255:0] - P) : t2[255:0];
  end

  // Register the reduced product and flag completion
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= start;
      if (start) result <= red;
    end
  end
endmodule

module jacobian_to_affine #(
  parameter logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] X,
  input  logic [255:0] Y,
  input  logic [255:0] Z,
  output logic [255:0] x_aff,
  output logic [255:0] y_aff,
  output logic         inf,
  output logic         busy,
  output logic         done
);
  localparam logic [255:0] E = P - 256'd2;

  typedef enum logic [3:0] {IDLE, SQR, MULZ, NEXT, ZI2, ZI3, XA, YA, FIN} state_t;
  state_t state;

  logic [255:0] xl, yl, zl, acc, zinv, zi2, zi3;
  logic [255:0] mul_a, mul_b, mul_result, op_a, op_b;
  logic [7:0]   idx;
  logic         start_mul, pend, mul_done, is_op, mul_take;

  jacobian_to_affine_mod_mul #(.P(P)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (start_mul),
    .a      (mul_a),
    .b      (mul_b),
    .result (mul_result),
    .done   (mul_done)
  );

  // A done seen while start_mul is still high belongs to an older product
  assign mul_take = pend && mul_done && !start_mul;
  assign is_op    = (state == SQR) || (state == MULZ) || (state == ZI2) ||
                    (state == ZI3) || (state == XA)   || (state == YA);

  // Operand selection for the multiply issued by the current state
  always_comb begin
    op_a = acc;
    op_b = acc;
    case (state)
      MULZ:    op_b = zl;
      ZI2:     begin op_a = zinv; op_b = zinv; end
      ZI3:     begin op_a = zi2;  op_b = zinv; end
      XA:      begin op_a = xl;   op_b = zi2;  end
      YA:      begin op_a = yl;   op_b = zi3;  end
      default: ;
    endcase
  end

  // Control FSM: square-and-multiply over E[254:0], then the four output products
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x_aff     <= '0;
      y_aff     <= '0;
      inf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      start_mul <= 1'b0;
      pend      <= 1'b0;
    end else begin
      done      <= 1'b0;
      start_mul <= 1'b0;
      if (is_op && !pend) begin
        mul_a     <= op_a;
        mul_b     <= op_b;
        start_mul <= 1'b1;
        pend      <= 1'b1;
      end
      if (mul_take) pend <= 1'b0;
      case (state)
        IDLE: if (start) begin
          xl <= X;
          yl <= Y;
          zl <= Z;
          if (Z == '0) begin
            inf   <= 1'b1;
            x_aff <= '0;
            y_aff <= '0;
            state <= FIN;
          end else begin
            inf   <= 1'b0;
            acc   <= Z;
            idx   <= 8'd254;
            busy  <= 1'b1;
            state <= SQR;
          end
        end
        SQR: if (mul_take) begin
          acc   <= mul_result;
          state <= E[idx] ? MULZ : NEXT;
        end
        MULZ: if (mul_take) begin
          acc   <= mul_result;
          state <= NEXT;
        end
        NEXT: begin
          if (idx == 8'd0) begin
            zinv  <= acc;
            state <= ZI2;
          end else begin
            idx   <= idx - 8'd1;
            state <= SQR;
          end
        end
        ZI2: if (mul_take) begin
          zi2   <= mul_result;
          state <= ZI3;
        end
        ZI3: if (mul_take) begin
          zi3   <= mul_result;
          state <= XA;
        end
        XA: if (mul_take) begin
          x_aff <= mul_result;
          state <= YA;
        end
        YA: if (mul_take) begin
          y_aff <= mul_result;
          state <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
